// File: rtl/vga_timing.sv
// Raster timing generator and VGA output stage: pixel enable, hc/vc counters,
// sync/blank delay line matched to the compositor pipeline, RGB332 -> 4:4:4.
module vga_timing #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int PIPE_DELAY  = 2,
  parameter int ANIM_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] color_in,
  output logic [9:0] hc,
  output logic [9:0] vc,
  output logic       pix_en,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start,
  output logic       ghost_animation
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST    = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  localparam int             FC_W    = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(ANIM_FRAMES - 1);

  // Delay-line word layout {visible, hs_n, vs_n}; idle = blank with syncs inactive.
  localparam logic [2:0] PIPE_IDLE = 3'b011;

  logic            r_pix_en;
  logic [9:0]      r_hc;
  logic [9:0]      r_vc;
  logic            r_frame_start;
  logic [FC_W-1:0] r_frame_cnt;
  logic            r_ghost;
  logic [3:0]      r_vga_r;
  logic [3:0]      r_vga_g;
  logic [3:0]      r_vga_b;
  logic            r_hsync;
  logic            r_vsync;

  logic       w_h_last;
  logic       w_v_last;
  logic       w_visible;
  logic       w_hs_n;
  logic       w_vs_n;
  logic [2:0] w_raw;
  logic [2:0] w_dly;

  assign w_h_last  = (r_hc == H_LAST);
  assign w_v_last  = (r_vc == V_LAST);
  assign w_visible = (r_hc < H_VIS_END) && (r_vc < V_VIS_END);
  assign w_hs_n    = !((r_hc >= HS_FIRST) && (r_hc <= HS_LAST));
  assign w_vs_n    = !((r_vc >= VS_FIRST) && (r_vc <= VS_LAST));
  assign w_raw     = {w_visible, w_hs_n, w_vs_n};

  // pix_en is a free-running divide-by-two; raster state moves only when it is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pix_en      <= 1'b0;
      r_hc          <= '0;
      r_vc          <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_pix_en      <= ~r_pix_en;
      r_frame_start <= r_pix_en && w_h_last && w_v_last;
      if (r_pix_en) begin
        if (w_h_last) begin
          r_hc <= '0;
          if (w_v_last) r_vc <= '0;
          else          r_vc <= r_vc + 10'd1;
        end else begin
          r_hc <= r_hc + 10'd1;
        end
      end
    end
  end

  generate
    if (PIPE_DELAY == 0) begin : g_no_pipe
      assign w_dly = w_raw;
    end else begin : g_pipe
      logic [2:0] r_pipe [PIPE_DELAY];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < PIPE_DELAY; i++) r_pipe[i] <= PIPE_IDLE;
        end else if (r_pix_en) begin
          r_pipe[0] <= w_raw;
          for (int i = 1; i < PIPE_DELAY; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end

      assign w_dly = r_pipe[PIPE_DELAY-1];
    end
  endgenerate

  // color_in arrives PIPE_DELAY ticks after its hc/vc, so it lines up with w_dly here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_vga_r <= '0;
      r_vga_g <= '0;
      r_vga_b <= '0;
    end else if (r_pix_en) begin
      r_hsync <= w_dly[1];
      r_vsync <= w_dly[0];
      if (w_dly[2]) begin
        r_vga_r <= {color_in[7:5], color_in[7]};
        r_vga_g <= {color_in[4:2], color_in[4]};
        r_vga_b <= {color_in[1:0], color_in[1:0]};
      end else begin
        r_vga_r <= '0;
        r_vga_g <= '0;
        r_vga_b <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_cnt <= '0;
      r_ghost     <= 1'b0;
    end else if (r_frame_start) begin
      if (r_frame_cnt == FC_LAST) begin
        r_frame_cnt <= '0;
        r_ghost     <= ~r_ghost;
      end else begin
        r_frame_cnt <= r_frame_cnt + FC_W'(1);
      end
    end
  end

  assign hc              = r_hc;
  assign vc              = r_vc;
  assign pix_en          = r_pix_en;
  assign vga_r           = r_vga_r;
  assign vga_g           = r_vga_g;
  assign vga_b           = r_vga_b;
  assign hsync           = r_hsync;
  assign vsync           = r_vsync;
  assign frame_start     = r_frame_start;
  assign ghost_animation = r_ghost;

endmodule

// File: doc/vga_timing.md
# vga_timing

Pixel-timing front end and output stage for the 640x480 display path. Divides the system clock into a 25 MHz pixel enable and generates the raster counters `hc`/`vc` consumed by the graphics compositor. Registers the compositor's RGB332 `color` back out as 4:4:4 VGA RGB, with sync and blanking delayed to match the compositor and RAM pipeline. Also produces the frame-start pulse and the `ghost_animation` toggle used by the sprite renderers.

## Interface
Parameters:
- `H_VISIBLE` 640; `H_FRONT` 16; `H_SYNC` 96; `H_BACK` 48: horizontal segments, in pixels.
- `V_VISIBLE` 480; `V_FRONT` 10; `V_SYNC` 2; `V_BACK` 33: vertical segments, in lines.
- `PIPE_DELAY` 2: pixel ticks from an `hc`/`vc` value to its matching `color_in`. Legal range 0..4.
- `ANIM_FRAMES` 8: frames per `ghost_animation` half-period. Must be ≥1.

Ports:
- `clk`  input  1  system clock, 50 MHz.
- `rst`  input  1  reset; asynchronous assertion, active-low.
- `color_in`  input  8  RGB332 pixel from the compositor, as {R[2:0], G[2:0], B[1:0]}.
- `hc`  output  10  horizontal counter, 0..799.
- `vc`  output  10  vertical counter, 0..524.
- `pix_en`  output  1  pixel-tick enable; high on every second `clk`.
- `vga_r`, `vga_g`, `vga_b`  output  4 each  DAC outputs.
- `hsync`, `vsync`  output  1 each  active-low syncs.
- `frame_start`  output  1  one-`clk` pulse at each raster wrap.
- `ghost_animation`  output  1  sprite animation phase.

## Operation
- **Reset values (rst low):**
  - `pix_en`=0, `hc`=0, `vc`=0.
  - `hsync`=1, `vsync`=1.
  - RGB=0, `frame_start`=0, `ghost_animation`=0.
  - Frame counter and all delay-line stages cleared to the "not visible, sync inactive" state.
- **Pixel enable:** `pix_en` toggles on every `clk` edge. All raster state advances only on edges where `pix_en` is sampled 1.
- **Counters:**
  - `hc` increments per tick and wraps from 799 to 0.
  - `vc` increments on the tick where `hc` wraps, and wraps from 524 to 0.
  - Totals are `H_VISIBLE+H_FRONT+H_SYNC+H_BACK` and the vertical equivalent. Counter arithmetic is 10-bit unsigned.
- **Raw decode, from current `hc`/`vc`:**
  - visible = `hc`<640 && `vc`<480.
  - hs_n = !(656 ≤ `hc` ≤ 751).
  - vs_n = !(490 ≤ `vc` ≤ 491).
- **Delay line:** {visible, hs_n, vs_n} pass through a `PIPE_DELAY`-stage shift register, advanced on pixel ticks.
- **Output register, updated on pixel ticks:**
  - `hsync`/`vsync` take the delayed hs_n/vs_n.
  - RGB = delayed visible ? expand(`color_in`) : 0.
  - Expansion: r={c[7:5],c[7]}, g={c[4:2],c[4]}, b={c[1:0],c[1:0]}.
- **Frame pulse:** `frame_start` is 1 for exactly one `clk`, namely the `clk` after the tick that moves (799,524) to (0,0). It is never asserted by reset release alone.
- **Animation:**
  - A frame counter (0..`ANIM_FRAMES`-1) advances on `frame_start`.
  - On wrap to 0, `ghost_animation` toggles.
- **Mid-operation reset:** all state returns to reset values immediately. The raster restarts from (0,0) after release with no partial-frame pulse.

## Timing
- `hc`/`vc` and `frame_start` are registered, so there is no combinational path from `color_in` to any output.
- Latency from an `hc`/`vc` value to the corresponding RGB/sync at the pins is `PIPE_DELAY`+1 pixel ticks (`2*(PIPE_DELAY+1)` `clk`).
- A full frame is 420000 pixel ticks, i.e. 840000 `clk`.
- `color_in` is sampled only on pixel-tick edges. It must be stable for the one `clk` before each tick.
- After reset release, the first `pix_en`=1 occurs after the first `clk` edge. `hc` first becomes 1 on the second edge.

## Test plan
- **Reset release:** hold `rst` low for 5 clk, then release.
  - Required: all outputs at their reset values while low.
  - `pix_en` follows 0,1,0,1 from release.
  - `hc`=1 after the 2nd edge; `vc`=0.
- **Line and frame wrap:** run to `hc`=799, `vc`=524.
  - Required: the next tick gives (0,0).
  - `frame_start` is high for exactly 1 clk; no other pulse within 840000 clk.
- **Sync placement:** with `PIPE_DELAY`=2, measure `hsync`.
  - Required: `hsync` goes low when raw `hc`=659 (656+3) and stays low for 96 ticks.
  - `vsync` is low for 2 lines starting on the line where raw `vc`=490, offset by 3 ticks.
- **Color path:**
  - Drive `color_in`=8'hE0 constantly → visible pixels give R=4'hF, G=0, B=0.
  - Drive 8'h03 → B=4'hF.
  - During `hc`≥640 (delayed), RGB=0 regardless of `color_in`.
- **Animation:** run with `ANIM_FRAMES`=2 over 4 frames.
  - Required: `ghost_animation` toggles on the 2nd and 4th `frame_start`.
- **Reset mid-frame:** assert `rst` at `hc`=300, `vc`=200.
  - Required: immediate return to reset values; the next `frame_start` comes a full 840000 clk after release.
